// File: rtl/mpu_pkg.sv
// Shared constants for the MPU6050 accelerometer reader: I2C engine op-codes,
// register addresses, FSM state encoding and the step-index landmarks.
package mpu_pkg;

  localparam logic [2:0] OP_START     = 3'd0;
  localparam logic [2:0] OP_WRITE     = 3'd1;
  localparam logic [2:0] OP_READ_ACK  = 3'd2;
  localparam logic [2:0] OP_READ_NACK = 3'd3;
  localparam logic [2:0] OP_STOP      = 3'd4;

  localparam logic [7:0] REG_PWR_MGMT_1   = 8'h6B;
  localparam logic [7:0] REG_ACCEL_XOUT_H = 8'h3B;

  localparam logic [4:0] WAKE_LAST    = 5'd4;
  localparam logic [4:0] READ_FIRST   = 5'd5;
  localparam logic [4:0] SHADOW_FIRST = 5'd10;  // first data byte of the burst
  localparam logic [4:0] READ_LAST    = 5'd16;

  typedef enum logic [2:0] {
    WAKE,
    READ,
    PUBLISH,
    DONE,
    ERR_STOP,
    BACKOFF
  } state_e;

endpackage

// File: rtl/mpu_reader_if.sv
// Command/response channel between mpu_reader and the byte-level I2C engine.
interface mpu_reader_if;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic [2:0] CMD_OP;
  logic [7:0] CMD_DATA;
  logic       RSP_VALID;
  logic [7:0] RSP_DATA;
  logic       RSP_NACK;

  modport master (output CMD_VALID, CMD_OP, CMD_DATA,
                  input  CMD_READY, RSP_VALID, RSP_DATA, RSP_NACK);
  modport slave  (input  CMD_VALID, CMD_OP, CMD_DATA,
                  output CMD_READY, RSP_VALID, RSP_DATA, RSP_NACK);
endinterface

// File: rtl/mpu_step_rom.sv
// Maps a step index to the I2C engine command: steps 0-4 wake the device,
// steps 5-16 burst-read the six accelerometer bytes.
module mpu_step_rom
  import mpu_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = 7'h68,
  parameter logic [7:0] START_REG = REG_ACCEL_XOUT_H
) (
  input  logic [4:0] step_i,
  output logic [2:0] op_o,
  output logic [7:0] data_o
);

  always_comb begin
    op_o   = OP_STOP;
    data_o = 8'h00;
    case (step_i)
      5'd0, 5'd5, 5'd8: op_o = OP_START;
      5'd1, 5'd6:       begin op_o = OP_WRITE; data_o = {DEV_ADDR, 1'b0}; end
      5'd2:             begin op_o = OP_WRITE; data_o = REG_PWR_MGMT_1;   end
      5'd3:             begin op_o = OP_WRITE; data_o = 8'h00;            end
      5'd7:             begin op_o = OP_WRITE; data_o = START_REG;        end
      5'd9:             begin op_o = OP_WRITE; data_o = {DEV_ADDR, 1'b1}; end
      5'd10, 5'd11, 5'd12, 5'd13, 5'd14: op_o = OP_READ_ACK;
      5'd15:            op_o = OP_READ_NACK;
      default:          op_o = OP_STOP;
    endcase
  end

endmodule

// File: rtl/mpu_reader.sv
// Wakes an MPU6050 and repeatedly burst-reads its accelerometer, publishing
// X/Y/Z high bytes atomically. Optional response watchdog: MPU_READER_WDOG_EN.
module mpu_reader
  import mpu_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = 7'h68,
  parameter logic [7:0] START_REG  = REG_ACCEL_XOUT_H,
  parameter int         RETRY_TICS = 8
`ifdef MPU_READER_WDOG_EN
  , parameter int       WDOG_CYCLES = 4096
`endif
) (
  input  logic       MCLK,
  input  logic       RST,
  input  logic       TIC,
  input  logic       RESCAN,
  output logic       COMPLETED,
  output logic [7:0] XREG,
  output logic [7:0] YREG,
  output logic [7:0] ZREG,
  output logic       ERR,
  mpu_reader_if.master bus
);

  localparam int TIC_W = $clog2(RETRY_TICS) + 1;
`ifdef MPU_READER_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES) + 1;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
`endif

  state_e     state_q, state_d;
  logic [4:0] step_q, step_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic [2:0] cmd_op_q, cmd_op_d;
  logic [7:0] cmd_data_q, cmd_data_d;
  logic       pending_q, pending_d;
  logic       completed_q, completed_d;
  logic       err_q, err_d;
  logic       rescan_q;
  logic [7:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [7:0] shadow_q [6];
  logic [7:0] shadow_d [6];
  logic [TIC_W-1:0] tic_q, tic_d;
  logic       rsp_ok;
  logic [2:0] shadow_idx;
  logic [2:0] rom_op;
  logic [7:0] rom_data;

  mpu_step_rom #(.DEV_ADDR(DEV_ADDR), .START_REG(START_REG)) u_rom (
    .step_i (step_d),
    .op_o   (rom_op),
    .data_o (rom_data)
  );

  assign rsp_ok     = pending_q && bus.RSP_VALID;
  assign shadow_idx = 3'(step_q - SHADOW_FIRST);

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    cmd_valid_d = cmd_valid_q;
    pending_d   = pending_q;
    completed_d = completed_q;
    err_d       = err_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    shadow_d    = shadow_q;
    tic_d       = tic_q;

    if (cmd_valid_q && bus.CMD_READY) begin
      cmd_valid_d = 1'b0;
      pending_d   = 1'b1;
    end
    if (rsp_ok) pending_d = 1'b0;

    case (state_q)
      WAKE, READ: begin
        if (!cmd_valid_q && !pending_q) begin
          cmd_valid_d = 1'b1;
        end else if (rsp_ok) begin
          if (cmd_op_q == OP_WRITE && bus.RSP_NACK) begin
            err_d       = 1'b1;
            state_d     = ERR_STOP;
            cmd_valid_d = 1'b1;
          end else begin
            if (cmd_op_q == OP_READ_ACK || cmd_op_q == OP_READ_NACK)
              shadow_d[shadow_idx] = bus.RSP_DATA;
            if (step_q == READ_LAST) begin
              state_d = PUBLISH;
            end else begin
              step_d      = step_q + 5'd1;
              cmd_valid_d = 1'b1;
              if (step_q == WAKE_LAST) state_d = READ;
            end
          end
        end
      end
      ERR_STOP: begin
        // The STOP response ends recovery regardless of its NACK bit.
        if (rsp_ok) begin
          state_d = BACKOFF;
          tic_d   = '0;
        end
      end
      BACKOFF: begin
        if (TIC) begin
          if (tic_q == TIC_W'(RETRY_TICS - 1)) begin
            state_d = WAKE;
            step_d  = 5'd0;
          end else begin
            tic_d = tic_q + 1'b1;
          end
        end
      end
      PUBLISH: begin
        x_d         = shadow_q[0];
        y_d         = shadow_q[2];
        z_d         = shadow_q[4];
        completed_d = 1'b1;
        err_d       = 1'b0;
        state_d     = DONE;
      end
      DONE: begin
        if (RESCAN && !rescan_q) begin
          completed_d = 1'b0;
          step_d      = READ_FIRST;
          state_d     = READ;
          cmd_valid_d = 1'b1;
        end
      end
      default: state_d = WAKE;
    endcase

`ifdef MPU_READER_WDOG_EN
    // The engine may be hung, so no STOP is attempted on a timeout.
    wdog_d = '0;
    if ((cmd_valid_q && !bus.CMD_READY) || (pending_q && !bus.RSP_VALID)) begin
      if (wdog_q == WDOG_W'(WDOG_CYCLES - 1)) begin
        err_d       = 1'b1;
        state_d     = BACKOFF;
        tic_d       = '0;
        cmd_valid_d = 1'b0;
        pending_d   = 1'b0;
      end else begin
        wdog_d = wdog_q + 1'b1;
      end
    end
`endif
  end

  // Op/data are latched only when a new command is raised, so they stay
  // stable for the whole CMD_VALID window.
  always_comb begin
    cmd_op_d   = cmd_op_q;
    cmd_data_d = cmd_data_q;
    if (cmd_valid_d && !cmd_valid_q) begin
      if (state_d == ERR_STOP) begin
        cmd_op_d   = OP_STOP;
        cmd_data_d = 8'h00;
      end else begin
        cmd_op_d   = rom_op;
        cmd_data_d = rom_data;
      end
    end
  end

  always_ff @(posedge MCLK or posedge RST) begin
    if (RST) begin
      state_q     <= WAKE;
      step_q      <= '0;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= OP_START;
      cmd_data_q  <= '0;
      pending_q   <= 1'b0;
      completed_q <= 1'b0;
      err_q       <= 1'b0;
      rescan_q    <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      tic_q       <= '0;
      for (int i = 0; i < 6; i++) shadow_q[i] <= '0;
`ifdef MPU_READER_WDOG_EN
      wdog_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_op_q    <= cmd_op_d;
      cmd_data_q  <= cmd_data_d;
      pending_q   <= pending_d;
      completed_q <= completed_d;
      err_q       <= err_d;
      rescan_q    <= RESCAN;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      tic_q       <= tic_d;
      shadow_q    <= shadow_d;
`ifdef MPU_READER_WDOG_EN
      wdog_q      <= wdog_d;
`endif
    end
  end

  assign bus.CMD_VALID = cmd_valid_q;
  assign bus.CMD_OP    = cmd_op_q;
  assign bus.CMD_DATA  = cmd_data_q;
  assign COMPLETED     = completed_q;
  assign ERR           = err_q;
  assign XREG          = x_q;
  assign YREG          = y_q;
  assign ZREG          = z_q;

endmodule

// File: tb/tb_mpu_reader.sv
// Self-checking bench for mpu_reader: an I2C engine model with a command
// scoreboard, random read data, and a sample-level model of the published bytes.
module tb_mpu_reader;
  import mpu_pkg::*;

  localparam logic [6:0] DEV = 7'h68;

  logic       MCLK = 1'b0;
  logic       RST  = 1'b1;
  logic       TIC  = 1'b0;
  logic       RESCAN = 1'b0;
  logic       COMPLETED, ERR;
  logic [7:0] XREG, YREG, ZREG;

  mpu_reader_if bus ();

  mpu_reader #(.DEV_ADDR(DEV), .START_REG(8'h3B), .RETRY_TICS(8)) dut (
    .MCLK      (MCLK),
    .RST       (RST),
    .TIC       (TIC),
    .RESCAN    (RESCAN),
    .COMPLETED (COMPLETED),
    .XREG      (XREG),
    .YREG      (YREG),
    .ZREG      (ZREG),
    .ERR       (ERR),
    .bus       (bus)
  );

  initial forever #5 MCLK = ~MCLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Expected command stream as given by the device protocol, {op, data}.
  logic [10:0] seq [17];
  logic [10:0] exp_q [$];
  logic [7:0]  rd_q [$];
  logic [7:0]  burst [$];
  logic [7:0]  exp_x, exp_y, exp_z;

  int  cmd_cnt = 0, rsp_cnt = 0, stall_n = 0, tic_cnt = 0, tic_at_stop = 0, cyc = 0;
  bit  stall_en = 0, nack_armed = 0, nack_fired = 0, gap_armed = 0, seen_rd_addr = 0;

  task automatic push_seq(input int first, input int last);
    for (int i = first; i <= last; i++) exp_q.push_back(seq[i]);
  endtask

  task automatic push_rand_bytes();
    for (int i = 0; i < 6; i++) rd_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic wait_completed(input int max_cyc, input string tag);
    int i;
    for (i = 0; i < max_cyc; i++) begin
      @(negedge MCLK);
      if (COMPLETED) break;
    end
    check_eq({tag, "_done_in_time"}, 32'(COMPLETED), 32'd1);
  endtask

  // Timebase: one TIC every 5 cycles.
  initial forever begin
    @(negedge MCLK);
    cyc++;
    TIC = (cyc % 5 == 0);
    if (TIC) tic_cnt++;
  end

  // Engine model: accepts commands, answers 3 cycles after each transfer.
  initial begin
    int         cnt;
    logic [7:0] pend_data;
    logic       pend_nack;
    logic [10:0] cmd;
    bit         busy;
    cnt = 0; pend_data = 0; pend_nack = 0;
    bus.CMD_READY = 1'b1; bus.RSP_VALID = 1'b0; bus.RSP_DATA = '0; bus.RSP_NACK = 1'b0;
    forever begin
      @(negedge MCLK);
      bus.RSP_VALID = 1'b0; bus.RSP_DATA = '0; bus.RSP_NACK = 1'b0;
      bus.CMD_READY = 1'b1;
      if (RST) begin
        cnt = 0;
        continue;
      end
      busy = (cnt > 0);
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.RSP_VALID = 1'b1; bus.RSP_DATA = pend_data; bus.RSP_NACK = pend_nack;
          rsp_cnt++;
        end
      end
      if (bus.CMD_VALID) begin
        cmd = {bus.CMD_OP, bus.CMD_DATA};
        if (stall_en && exp_q.size() > 0 && exp_q[0] == {OP_WRITE, REG_PWR_MGMT_1} && stall_n < 10) begin
          bus.CMD_READY = 1'b0;
          stall_n++;
          check_eq("stall_op", 32'(bus.CMD_OP), 32'(OP_WRITE));
          check_eq("stall_data", 32'(bus.CMD_DATA), 32'h6B);
        end else begin
          cmd_cnt++;
          check_eq("single_outstanding", 32'(busy), 32'd0);
          check_eq("cmd_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) check_eq("cmd_opdata", 32'(cmd), 32'(exp_q.pop_front()));
          $display("cmd #%0d op=%0d data=%02h", cmd_cnt, bus.CMD_OP, bus.CMD_DATA);
          pend_data = 8'h00; pend_nack = 1'b0;
          if (bus.CMD_OP == OP_READ_ACK || bus.CMD_OP == OP_READ_NACK) begin
            pend_data = (rd_q.size() > 0) ? rd_q.pop_front() : 8'h00;
            burst.push_back(pend_data);
            if (bus.CMD_OP == OP_READ_NACK && burst.size() == 6) begin
              exp_x = burst[0]; exp_y = burst[2]; exp_z = burst[4];
              burst.delete();
            end
          end
          if (bus.CMD_OP == OP_WRITE && bus.CMD_DATA == {DEV, 1'b1}) begin
            seen_rd_addr = 1;
            if (nack_armed) begin
              pend_nack = 1'b1; nack_armed = 0; nack_fired = 1;
            end
          end
          if (gap_armed && bus.CMD_OP == OP_START) begin
            gap_armed = 0;
            check_eq("backoff_tic_gap_ok",
                     32'((tic_cnt - tic_at_stop) >= 8 && (tic_cnt - tic_at_stop) <= 10), 32'd1);
          end
          if (nack_fired && bus.CMD_OP == OP_STOP) begin
            nack_fired = 0; gap_armed = 1; tic_at_stop = tic_cnt;
          end
          cnt = 3;
        end
      end
    end
  end

  initial begin
    logic [23:0] old_xyz;
    bit saw_low, mixed;
    int base;
    seq[0]  = {OP_START, 8'h00};       seq[1]  = {OP_WRITE, DEV, 1'b0};
    seq[2]  = {OP_WRITE, 8'h6B};       seq[3]  = {OP_WRITE, 8'h00};
    seq[4]  = {OP_STOP, 8'h00};        seq[5]  = {OP_START, 8'h00};
    seq[6]  = {OP_WRITE, DEV, 1'b0};   seq[7]  = {OP_WRITE, 8'h3B};
    seq[8]  = {OP_START, 8'h00};       seq[9]  = {OP_WRITE, DEV, 1'b1};
    for (int i = 10; i < 15; i++) seq[i] = {OP_READ_ACK, 8'h00};
    seq[15] = {OP_READ_NACK, 8'h00};   seq[16] = {OP_STOP, 8'h00};

    // Reset state
    repeat (3) @(negedge MCLK);
    check_eq("rst_cmd_valid", 32'(bus.CMD_VALID), 32'd0);
    check_eq("rst_cmd_op", 32'(bus.CMD_OP), 32'd0);
    check_eq("rst_cmd_data", 32'(bus.CMD_DATA), 32'd0);
    check_eq("rst_completed", 32'(COMPLETED), 32'd0);
    check_eq("rst_xyz", {8'h0, XREG, YREG, ZREG}, 32'd0);
    check_eq("rst_err", 32'(ERR), 32'd0);

    // First wake + burst with fixed bytes
    rd_q = '{8'h12, 8'h34, 8'hF0, 8'h01, 8'h80, 8'h00};
    push_seq(0, 16);
    RST = 1'b0;
    wait_completed(400, "burst1");
    check_eq("b1_x", 32'(XREG), 32'h12);
    check_eq("b1_y", 32'(YREG), 32'hF0);
    check_eq("b1_z", 32'(ZREG), 32'h80);
    check_eq("b1_err", 32'(ERR), 32'd0);
    repeat (20) @(negedge MCLK);
    check_eq("b1_cmd_count", 32'(cmd_cnt), 32'd17);
    check_eq("b1_queue_empty", 32'(exp_q.size()), 32'd0);
    check_eq("b1_completed_hold", 32'(COMPLETED), 32'd1);

    // Rescan held high: exactly one burst, outputs coherent until publish
    push_seq(5, 16);
    push_rand_bytes();
    old_xyz = {XREG, YREG, ZREG};
    saw_low = 0; mixed = 0;
    RESCAN = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge MCLK);
      if (!COMPLETED) begin
        saw_low = 1;
        if ({XREG, YREG, ZREG} != old_xyz) mixed = 1;
      end else if (saw_low) break;
    end
    check_eq("b2_completed_dropped", 32'(saw_low), 32'd1);
    check_eq("b2_completed", 32'(COMPLETED), 32'd1);
    check_eq("b2_no_mixed", 32'(mixed), 32'd0);
    check_eq("b2_xyz", {8'h0, XREG, YREG, ZREG}, {8'h0, exp_x, exp_y, exp_z});
    repeat (50) @(negedge MCLK);
    check_eq("b2_cmd_count", 32'(cmd_cnt), 32'd29);
    RESCAN = 1'b0;

    // NACK on read address, backoff, re-wake with stalled step 2
    repeat (5) @(negedge MCLK);
    nack_armed = 1; stall_en = 1;
    push_seq(5, 9);
    exp_q.push_back({OP_STOP, 8'h00});
    push_seq(0, 16);
    push_rand_bytes();
    RESCAN = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge MCLK);
      if (ERR) break;
    end
    check_eq("nack_err", 32'(ERR), 32'd1);
    check_eq("nack_completed", 32'(COMPLETED), 32'd0);
    wait_completed(2000, "retry");
    check_eq("retry_err_cleared", 32'(ERR), 32'd0);
    check_eq("retry_xyz", {8'h0, XREG, YREG, ZREG}, {8'h0, exp_x, exp_y, exp_z});
    check_eq("stall_cycles", 32'(stall_n), 32'd10);
    check_eq("retry_cmd_count", 32'(cmd_cnt), 32'd52);
    RESCAN = 1'b0;
    stall_en = 0;

    // Asynchronous reset while waiting on the step-9 response
    repeat (5) @(negedge MCLK);
    push_seq(5, 16);
    push_rand_bytes();
    seen_rd_addr = 0;
    RESCAN = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge MCLK);
      if (seen_rd_addr) break;
    end
    check_eq("rst_mid_reached", 32'(seen_rd_addr), 32'd1);
    @(posedge MCLK);
    #1 RST = 1'b1;
    #1;
    check_eq("arst_xyz", {8'h0, XREG, YREG, ZREG}, 32'd0);
    check_eq("arst_cmd_valid", 32'(bus.CMD_VALID), 32'd0);
    check_eq("arst_cmd_op", 32'(bus.CMD_OP), 32'd0);
    check_eq("arst_err", 32'(ERR), 32'd0);
    exp_q.delete(); rd_q.delete(); burst.delete();
    RESCAN = 1'b0;
    repeat (3) @(negedge MCLK);
    base = cmd_cnt;
    push_seq(0, 16);
    push_rand_bytes();
    RST = 1'b0;
    wait_completed(400, "post_rst");
    check_eq("post_rst_xyz", {8'h0, XREG, YREG, ZREG}, {8'h0, exp_x, exp_y, exp_z});
    check_eq("post_rst_cmds", 32'(cmd_cnt - base), 32'd17);
    check_eq("post_rst_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
